// File: rtl/coeff_bank_mb.sv
// Double-buffered, multi-band symmetric FIR coefficient store (half taps stored, mirrored reads).
// Optional build macro COEFF_BANK_PASSTHRU_EN: S_INIT loads a pass-through filter instead of zeros.
module coeff_bank_mb #(
  parameter int COEFF_W   = 16,
  parameter int NUM_TAPS  = 64,
  parameter int NUM_BANDS = 8,
  parameter int TAP_W     = $clog2(NUM_TAPS),
  parameter int BAND_W    = $clog2(NUM_BANDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [BAND_W-1:0]  rd_band,
  input  logic [TAP_W-1:0]   rd_tap,
  output logic [COEFF_W-1:0] rd_coeff,
  output logic               rd_valid,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BAND_W-1:0]  wr_band,
  input  logic [TAP_W-2:0]   wr_tap,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic               swap_req,
  input  logic               frame_start,
  output logic               swap_pending,
  output logic               active_bank,
  output logic               busy
);

  localparam int HALF   = NUM_TAPS / 2;
  localparam int DEPTH  = NUM_BANDS * HALF;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_COPY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                active_q, active_d;
  logic                pending_q, pending_d;
  logic [COEFF_W-1:0]  rd_coeff_q, rd_coeff_d;
  logic                rd_valid_q;
  logic [COEFF_W-1:0]  mem_q [2][DEPTH];

  logic                cnt_last;
  logic                swap_go;
  logic [TAP_W-1:0]    rd_idx;
  logic                rd_in_range;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_in_range;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COEFF_W-1:0]  init_val;
  logic [1:0]          mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [COEFF_W-1:0]  mem_wdata;

  assign cnt_last = (cnt_q == CNT_LAST);
  // The swap only looks at the registered pending flag, so a same-cycle swap_req waits a frame.
  assign swap_go  = (state_q == S_RUN) && pending_q && frame_start;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb assigns defaults first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (cnt_last) state_d = S_RUN;
      S_RUN:   if (swap_go)  state_d = S_COPY;
      S_COPY:  if (cnt_last) state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_RUN);
    wr_ready = (state_q == S_RUN) && !pending_q;
  end

  always_comb begin
    cnt_d     = (state_q == S_RUN || cnt_last) ? '0 : cnt_q + ADDR_W'(1);
    active_d  = active_q ^ swap_go;
    pending_d = pending_q;
    if (swap_go)                               pending_d = 1'b0;
    else if (state_q != S_INIT && swap_req)    pending_d = 1'b1;
  end

  // Read path: mirror the upper half of the tap range onto the stored half.
  always_comb begin
    rd_idx      = (rd_tap < TAP_W'(HALF)) ? rd_tap : TAP_W'(NUM_TAPS - 1) - rd_tap;
    rd_in_range = ({1'b0, rd_band} < (BAND_W + 1)'(NUM_BANDS)) &&
                  ({1'b0, rd_tap}  < (TAP_W + 1)'(NUM_TAPS));
    rd_addr     = ADDR_W'(int'(rd_band) * HALF + int'(rd_idx));
    rd_coeff_d  = rd_coeff_q;
    if (rd_en) begin
      if (state_q == S_INIT || !rd_in_range) rd_coeff_d = '0;
      else                                   rd_coeff_d = mem_q[active_q][rd_addr];
    end
  end

  always_comb begin
`ifdef COEFF_BANK_PASSTHRU_EN
    init_val = ((int'(cnt_q) % HALF) == HALF - 1) ? COEFF_W'(16'h3FFF) : '0;
`else
    init_val = '0;
`endif
  end

  // Single write port per bank, shared by init fill, post-swap copy and host writes.
  always_comb begin
    wr_in_range = ({1'b0, wr_band} < (BAND_W + 1)'(NUM_BANDS)) &&
                  ({1'b0, wr_tap}  < TAP_W'(HALF));
    wr_addr     = ADDR_W'(int'(wr_band) * HALF + int'(wr_tap));
    mem_we      = 2'b00;
    mem_waddr   = cnt_q;
    mem_wdata   = init_val;
    case (state_q)
      S_INIT: mem_we = 2'b11;
      S_COPY: begin
        mem_we[~active_q] = 1'b1;
        mem_wdata         = mem_q[active_q][cnt_q];
      end
      S_RUN: begin
        if (wr_valid && wr_ready && wr_in_range) mem_we[~active_q] = 1'b1;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
      default: mem_we = 2'b00;
    endcase
    if (!rst_n) mem_we = 2'b00;
  end

  // NOTE: the coefficient array has no reset; S_INIT rewrites every entry after reset instead.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_we[b]) mem_q[b][mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      active_q   <= 1'b0;
      pending_q  <= 1'b0;
      rd_coeff_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      rd_coeff_q <= rd_coeff_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_coeff     = rd_coeff_q;
  assign rd_valid     = rd_valid_q;
  assign swap_pending = pending_q;
  assign active_bank  = active_q;

endmodule
